// File: rtl/ram_bitmask_req_ctrl.sv
// ram_bitmask_req_ctrl
//   Initiator-side controller for one port of the bitmask dual-port RAM.
//   In-order read/write requests arrive on a valid/ready channel and are
//   forwarded combinationally to the RAM port. The RAM's 1-cycle registered
//   read data is either bypassed straight to the response channel or parked
//   in a small response FIFO. Requests are only accepted while a FIFO slot is
//   guaranteed, so read data is never lost under response backpressure.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write                1 = write, 0 = read
//   req_addr/data/mask       word address, write data, per-bit write enable
//   rsp_valid/rsp_ready      read response handshake
//   rsp_data                 read data (0 when nothing is pending)
//   ram_cen/wen/bwen/addr/din  RAM port controls
//   ram_dout                 RAM registered read data
//   rd_pending               reads in flight plus entries held in the FIFO
module ram_bitmask_req_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned RSP_DEPTH  = 2,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
   localparam int unsigned CNT_WIDTH  = $clog2(RSP_DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic [DATA_WIDTH-1:0] req_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  ram_cen,
   output logic                  ram_wen,
   output logic [DATA_WIDTH-1:0] ram_bwen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [CNT_WIDTH-1:0]  rd_pending
);

   localparam int unsigned PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned PTR_LAST_I = RSP_DEPTH - 1;
   localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_LAST_I[PTR_WIDTH-1:0];
   localparam logic [CNT_WIDTH:0] RSP_DEPTH_C = RSP_DEPTH[CNT_WIDTH:0];

   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   logic                  accept;
   logic                  fifo_empty;
   logic                  push, pop;
   logic [CNT_WIDTH:0]    used;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   // A slot is reserved for every read in flight, so the FIFO can never
   // overflow. Writes also wait for credit to keep strict request order.
   assign used       = {1'b0, count_q} + (CNT_WIDTH + 1)'(inflight_q);
   assign req_ready  = !reset && (used < RSP_DEPTH_C);
   assign accept     = req_valid && req_ready;
   assign fifo_empty = (count_q == '0);

   // Issue path: zero added latency, data/mask zeroed when idle.
   assign ram_cen  = accept;
   assign ram_wen  = accept && req_write;
   assign ram_addr = req_addr;
   assign ram_bwen = accept ? req_mask : '0;
   assign ram_din  = accept ? req_data : '0;

   assign inflight_d = accept && !req_write;
   assign rd_pending = count_q + CNT_WIDTH'(inflight_q);

   // With an empty FIFO the returning read word is presented directly and
   // only stored if the consumer stalls; otherwise it queues behind the head.
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      if (inflight_q) begin
         if (fifo_empty) begin
            push = !rsp_ready;
         end else begin
            push = 1'b1;
            pop  = rsp_ready;
         end
      end else begin
         pop = !fifo_empty && rsp_ready;
      end
   end

   assign rsp_valid = !reset && (!fifo_empty || inflight_q);

   always_comb begin
      rsp_data = '0;
      if (!fifo_empty) begin
         rsp_data = fifo_q[rd_ptr_q];
      end else if (inflight_q) begin
         rsp_data = ram_dout;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q says valid.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         fifo_q[wr_ptr_q] <= ram_dout;
      end
   end

endmodule

// File: tb/tb_ram_bitmask_req_ctrl.sv
module tb_ram_bitmask_req_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned RD    = 2;
   localparam int unsigned AW    = 4;
   localparam int unsigned CW    = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data, req_mask;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          ram_cen, ram_wen;
   logic [DW-1:0] ram_bwen, ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic [AW-1:0] ram_addr;
   logic [CW-1:0] rd_pending;

   int total = 0;
   int bad   = 0;
   bit mon_en = 0;

   always #5 clock = ~clock;

   ram_bitmask_req_ctrl #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .RSP_DEPTH(RD)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .rd_pending(rd_pending)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM port model driven purely from the ram_* pins.
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clock) begin
      if (ram_cen) begin
         if (ram_wen) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_bwen) | (ram_din & ram_bwen);
         else         ram_dout <= ram_mem[ram_addr];
      end
   end

   // Reference model driven from the request channel: a shadow memory, a queue
   // of expected read words and a count of accepted-but-unconsumed reads.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int pending = 0;

   always @(posedge clock) begin
      bit can_take;
      if (reset) begin
         exp_q.delete();
         pending = 0;
      end else begin
         can_take = (pending < RD);
         if (pending != 0 && rsp_ready) begin
            void'(exp_q.pop_front());
            pending--;
         end
         if (req_valid && can_take) begin
            if (req_write) begin
               ref_mem[req_addr] = (ref_mem[req_addr] & ~req_mask) | (req_data & req_mask);
            end else begin
               exp_q.push_back(ref_mem[req_addr]);
               pending++;
            end
         end
      end
   end

   always @(negedge clock) begin
      bit en;
      if (mon_en && !reset) begin
         en = req_valid && (pending < RD);
         chk("m_req_ready", req_ready, pending < RD);
         chk("m_rd_pending", rd_pending, pending);
         chk("m_no_overflow", rd_pending <= RD, 1);
         chk("m_rsp_valid", rsp_valid, pending != 0);
         if (pending != 0) chk("m_rsp_data", rsp_data, exp_q[0]);
         else              chk("m_rsp_data_idle", rsp_data, 0);
         chk("m_ram_cen", ram_cen, en);
         chk("m_ram_wen", ram_wen, en && req_write);
         chk("m_ram_addr", ram_addr, req_addr);
         chk("m_ram_bwen", ram_bwen, en ? req_mask : '0);
         chk("m_ram_din", ram_din, en ? req_data : '0);
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
   endtask

   // Drive one request and hold it until accepted (bounded).
   task automatic do_req(input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
      int n = 0;
      drive(1, w, a, d, m);
      @(negedge clock);
      while (!req_ready && n < 20) begin
         next_cycle();
         @(negedge clock);
         n++;
      end
      chk("accept_in_time", req_ready, 1);
      next_cycle();
      req_valid = 0;
   endtask

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] mask;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [12];
   logic [DW-1:0] vals [3];

   initial begin
      int k;
      bit acc;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end

      vecs[0]  = '{1, 3,  32'hDEADBEEF, 32'hFFFFFFFF, 0};
      vecs[1]  = '{0, 3,  0,            0,            32'hDEADBEEF};
      vecs[2]  = '{1, 5,  32'hDEADBEEF, 32'hFFFFFFFF, 0};
      vecs[3]  = '{1, 5,  32'h12345678, 32'h0000FFFF, 0};
      vecs[4]  = '{0, 5,  0,            0,            32'hDEAD5678};
      vecs[5]  = '{1, 7,  32'hAAAA5555, 32'hFF00FF00, 0};
      vecs[6]  = '{0, 7,  0,            0,            32'hAA005500};
      vecs[7]  = '{1, 3,  32'h00000000, 32'h000000F0, 0};
      vecs[8]  = '{0, 3,  0,            0,            32'hDEADBE0F};
      vecs[9]  = '{1, 15, 32'hFFFFFFFF, 32'h80000001, 0};
      vecs[10] = '{0, 15, 0,            0,            32'h80000001};
      vecs[11] = '{0, 0,  0,            0,            32'h00000000};

      // Reset state, with a request pending to show it is not issued.
      reset = 1;
      rsp_ready = 0;
      drive(1, 0, 4, 32'h1, 32'h1);
      repeat (3) next_cycle();
      @(negedge clock);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ram_cen", ram_cen, 0);
      chk("rst_rd_pending", rd_pending, 0);
      chk("rst_rsp_data", rsp_data, 0);
      next_cycle();
      reset = 0;
      req_valid = 0;
      mon_en = 1;
      @(negedge clock);
      chk("post_rst_ready", req_ready, 1);
      next_cycle();

      // Table-driven single requests with a ready consumer.
      rsp_ready = 1;
      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask);
         if (!vecs[i].wr) begin
            @(negedge clock);
            chk("tbl_rsp_valid", rsp_valid, 1);
            chk("tbl_rsp_data", rsp_data, vecs[i].exp);
            next_cycle();
            @(negedge clock);
            chk("tbl_rsp_gone", rsp_valid, 0);
            chk("tbl_cen_idle", ram_cen, 0);
            next_cycle();
         end
      end

      // Backpressure: three reads with the consumer stalled.
      vals[0] = 32'h0BAD0000;
      vals[1] = 32'h0BAD1111;
      vals[2] = 32'h0BAD2222;
      for (int i = 0; i < 3; i++) do_req(1, AW'(i), vals[i], 32'hFFFFFFFF);
      rsp_ready = 0;
      drive(1, 0, 0, 0, 0);
      @(negedge clock);
      chk("bp_ready0", req_ready, 1);
      next_cycle();
      req_addr = 1;
      @(negedge clock);
      chk("bp_ready1", req_ready, 1);
      chk("bp_bypass_valid", rsp_valid, 1);
      chk("bp_bypass_data", rsp_data, vals[0]);
      next_cycle();
      req_addr = 2;
      @(negedge clock);
      chk("bp_ready2", req_ready, 0);
      chk("bp_pending", rd_pending, 2);
      chk("bp_hold_data", rsp_data, vals[0]);
      next_cycle();
      @(negedge clock);
      chk("bp_still_full", req_ready, 0);
      chk("bp_hold_data2", rsp_data, vals[0]);
      next_cycle();
      rsp_ready = 1;
      k = 0;
      for (int c = 0; c < 20 && k < 3; c++) begin
         @(negedge clock);
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            chk("bp_order", rsp_data, vals[k]);
            k++;
         end
         next_cycle();
         if (acc) req_valid = 0;
      end
      chk("bp_all_returned", k, 3);
      next_cycle();

      // Full throughput: back-to-back reads, one response per cycle.
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, AW'(i), 0, 0);
         @(negedge clock);
         chk("tp_ready", req_ready, 1);
         if (i > 0) begin
            chk("tp_rsp_valid", rsp_valid, 1);
            chk("tp_pending", rd_pending, 1);
         end
         next_cycle();
      end
      req_valid = 0;
      @(negedge clock);
      chk("tp_last_valid", rsp_valid, 1);
      next_cycle();
      @(negedge clock);
      chk("tp_drained", rd_pending, 0);
      next_cycle();

      // Simultaneous push and pop with one entry buffered.
      rsp_ready = 0;
      drive(1, 0, 0, 0, 0);
      next_cycle();
      req_addr = 1;
      next_cycle();
      req_valid = 0;
      rsp_ready = 1;
      @(negedge clock);
      chk("pp_pending_before", rd_pending, 2);
      chk("pp_head_before", rsp_data, vals[0]);
      next_cycle();
      @(negedge clock);
      chk("pp_pending_after", rd_pending, 1);
      chk("pp_valid_after", rsp_valid, 1);
      chk("pp_head_after", rsp_data, vals[1]);
      next_cycle();
      @(negedge clock);
      chk("pp_empty", rd_pending, 0);
      next_cycle();

      // Reset with one entry buffered and a read in flight.
      rsp_ready = 0;
      drive(1, 0, 0, 0, 0);
      next_cycle();
      req_addr = 1;
      next_cycle();
      reset = 1;
      req_addr = 2;
      @(negedge clock);
      chk("mr_rsp_valid_in_rst", rsp_valid, 0);
      chk("mr_cen_in_rst", ram_cen, 0);
      chk("mr_ready_in_rst", req_ready, 0);
      next_cycle();
      reset = 0;
      req_valid = 0;
      rsp_ready = 1;
      @(negedge clock);
      chk("mr_pending", rd_pending, 0);
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_ready", req_ready, 1);
      repeat (3) next_cycle();

      // Random traffic against the reference model, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 199) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = $urandom_range(0, 1);
         req_addr  = AW'($urandom_range(0, DEPTH - 1));
         req_data  = $urandom;
         req_mask  = $urandom;
         rsp_ready = ($urandom_range(0, 2) != 0);
         next_cycle();
      end
      reset = 0;
      req_valid = 0;
      rsp_ready = 1;
      repeat (5) next_cycle();
      @(negedge clock);
      chk("final_drained", rd_pending, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
